// File: rtl/psram_fb_scheduler.sv
// Burst scheduler for a double-buffered camera-to-VGA PSRAM frame store.
// Arbitrates camera writes against VGA reads and swaps buffers on completed frames.
module psram_fb_scheduler #(
    parameter int                ADDR_W         = 23,
    parameter int                BURST_LEN      = 128,
    parameter int                FRAME_WORDS    = 307200,
    parameter logic [ADDR_W-1:0] BUF0_BASE      = 23'h000000,
    parameter logic [ADDR_W-1:0] BUF1_BASE      = 23'h080000,
    parameter logic [ADDR_W-1:0] SCRATCH_BASE   = 23'h100000,
    parameter int                PREFILL_BURSTS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cam_req,
    input  logic              vga_req,
    input  logic              cam_frame_start,
    input  logic              vga_frame_start,
    input  logic              brst_Done,
    output logic              brst_Go,
    output logic              brst_Wr,
    output logic [ADDR_W-1:0] brst_Addr,
    output logic              vga_rst,
    output logic              disp_buf,
    output logic              swap,
    output logic              frame_drop
);

    localparam logic [ADDR_W-1:0] BURST_W = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_W = ADDR_W'(FRAME_WORDS);
    localparam int                PF_W    = $clog2(PREFILL_BURSTS + 1) + 1;
    localparam logic [PF_W-1:0]   PF_LAST = PF_W'(PREFILL_BURSTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_POST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pending;
    logic              prio_cam;
    logic              cur_drop;
    logic              cam_hold;
    logic              vga_hold;
    logic [PF_W-1:0]   prefill_cnt;

    logic              done_now;
    logic [ADDR_W-1:0] base_wr;
    logic [ADDR_W-1:0] base_rd;
    logic              base_pending;
    logic              ev_cam;
    logic              ev_vga;
    logic [ADDR_W-1:0] new_wr;
    logic [ADDR_W-1:0] new_rd;
    logic              new_pending;
    logic              do_swap;
    logic              new_disp;
    logic              sel_vga;
    logic              sel_cam;
    logic              cam_full;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Pointer advance of a completing burst comes first, then the frame events
    // (camera before VGA), so a frame-start reset wins over the increment.
    always_comb begin
        done_now     = (state == S_WAIT) && brst_Done;
        base_wr      = wr_ptr;
        base_rd      = rd_ptr;
        base_pending = pending;
        if (done_now) begin
            if (brst_Wr && !cur_drop) begin
                base_wr = wr_ptr + BURST_W;
                if (base_wr == FRAME_W) begin
                    base_pending = 1'b1;
                end
            end else if (!brst_Wr) begin
                base_rd = (rd_ptr + BURST_W == FRAME_W) ? '0 : rd_ptr + BURST_W;
            end
        end

        ev_cam      = cam_hold | cam_frame_start;
        ev_vga      = vga_hold | vga_frame_start;
        new_wr      = ev_cam ? '0 : base_wr;
        new_pending = ev_cam ? 1'b0 : base_pending;
        do_swap     = ev_vga && new_pending;
        new_pending = new_pending && !do_swap;
        new_disp    = disp_buf ^ do_swap;
        new_rd      = ev_vga ? '0 : base_rd;

        sel_vga  = vga_req && !(prio_cam && cam_req);
        sel_cam  = cam_req && !sel_vga;
        cam_full = (new_wr == FRAME_W);
        wr_addr  = cam_full ? SCRATCH_BASE : ((new_disp ? BUF0_BASE : BUF1_BASE) + new_wr);
        rd_addr  = (new_disp ? BUF1_BASE : BUF0_BASE) + new_rd;
    end

    // Frame events are deferred while a burst is in flight and merged into its completion.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            brst_Go     <= 1'b0;
            brst_Wr     <= 1'b0;
            brst_Addr   <= '0;
            vga_rst     <= 1'b1;
            disp_buf    <= 1'b1;
            swap        <= 1'b0;
            frame_drop  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending     <= 1'b0;
            prio_cam    <= 1'b0;
            cur_drop    <= 1'b0;
            cam_hold    <= 1'b0;
            vga_hold    <= 1'b0;
            prefill_cnt <= '0;
        end else begin
            brst_Go    <= 1'b0;
            swap       <= 1'b0;
            frame_drop <= 1'b0;

            if (state == S_ISSUE || (state == S_WAIT && !brst_Done)) begin
                cam_hold <= ev_cam;
                vga_hold <= ev_vga;
            end else begin
                wr_ptr   <= new_wr;
                rd_ptr   <= new_rd;
                pending  <= new_pending;
                disp_buf <= new_disp;
                swap     <= do_swap;
                cam_hold <= 1'b0;
                vga_hold <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (sel_vga || sel_cam) begin
                        brst_Go    <= 1'b1;
                        brst_Wr    <= sel_cam;
                        brst_Addr  <= sel_cam ? wr_addr : rd_addr;
                        cur_drop   <= sel_cam && cam_full;
                        frame_drop <= sel_cam && cam_full;
                        prio_cam   <= sel_vga;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (brst_Done) begin
                        state <= S_POST;
                        if (!brst_Wr && vga_rst) begin
                            if (prefill_cnt == PF_LAST) begin
                                vga_rst <= 1'b0;
                            end
                            prefill_cnt <= prefill_cnt + 1'b1;
                        end
                    end
                end
                S_POST:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_fb_scheduler.sv
// Randomized and directed bench for psram_fb_scheduler against a burst-level reference model.
module tb_psram_fb_scheduler;

    localparam int          AW      = 23;
    localparam int          BL      = 128;
    localparam int          FW      = 512;
    localparam int          PF      = 2;
    localparam logic [22:0] BUF0    = 23'h000000;
    localparam logic [22:0] BUF1    = 23'h080000;
    localparam logic [22:0] SCRATCH = 23'h100000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cam_req = 1'b0;
    logic          vga_req = 1'b0;
    logic          cam_frame_start = 1'b0;
    logic          vga_frame_start = 1'b0;
    logic          brst_Done = 1'b0;
    logic          brst_Go;
    logic          brst_Wr;
    logic [AW-1:0] brst_Addr;
    logic          vga_rst;
    logic          disp_buf;
    logic          swap;
    logic          frame_drop;

    psram_fb_scheduler #(
        .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW),
        .BUF0_BASE(BUF0), .BUF1_BASE(BUF1), .SCRATCH_BASE(SCRATCH),
        .PREFILL_BURSTS(PF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cam_req(cam_req), .vga_req(vga_req),
        .cam_frame_start(cam_frame_start), .vga_frame_start(vga_frame_start),
        .brst_Done(brst_Done), .brst_Go(brst_Go), .brst_Wr(brst_Wr),
        .brst_Addr(brst_Addr), .vga_rst(vga_rst), .disp_buf(disp_buf),
        .swap(swap), .frame_drop(frame_drop)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_due = -100;
    int dut_wr_gos = 0;

    // Reference model: frame buffer bookkeeping per burst
    int          m_wptr, m_rptr, m_reads;
    logic        m_pending, m_disp, m_last_vga, m_busy, m_cool;
    logic        m_hold_c, m_hold_v, m_cur_wr, m_cur_drop;
    logic        m_go, m_wr, m_drop, m_swap, m_vga_rst;
    logic [22:0] m_addr;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic frameEvents(input logic c, input logic v);
        if (c) begin
            m_wptr    = 0;
            m_pending = 1'b0;
        end
        if (v) begin
            m_rptr = 0;
            if (m_pending) begin
                m_disp    = ~m_disp;
                m_pending = 1'b0;
                m_swap    = 1'b1;
            end
        end
    endtask

    task automatic modelStep(input logic cr, input logic vr, input logic cfs, input logic vfs,
                             input logic done, input logic rstn);
        logic use_vga;
        m_go   = 1'b0;
        m_drop = 1'b0;
        m_swap = 1'b0;
        if (!rstn) begin
            m_wptr = 0; m_rptr = 0; m_reads = 0;
            m_pending = 1'b0; m_disp = 1'b1; m_last_vga = 1'b0;
            m_busy = 1'b0; m_cool = 1'b0; m_hold_c = 1'b0; m_hold_v = 1'b0;
            m_cur_wr = 1'b0; m_cur_drop = 1'b0;
            m_wr = 1'b0; m_addr = '0; m_vga_rst = 1'b1;
        end else if (m_busy) begin
            m_hold_c = m_hold_c | cfs;
            m_hold_v = m_hold_v | vfs;
            if (done) begin
                if (m_cur_wr) begin
                    if (!m_cur_drop) begin
                        m_wptr = m_wptr + BL;
                        if (m_wptr == FW) m_pending = 1'b1;
                    end
                end else begin
                    m_rptr  = (m_rptr + BL) % FW;
                    m_reads = m_reads + 1;
                    if (m_reads >= PF) m_vga_rst = 1'b0;
                end
                frameEvents(m_hold_c, m_hold_v);
                m_hold_c = 1'b0;
                m_hold_v = 1'b0;
                m_busy   = 1'b0;
                m_cool   = 1'b1;
            end
        end else begin
            frameEvents(cfs, vfs);
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (cr || vr) begin
                use_vga    = vr && !(m_last_vga && cr);
                m_last_vga = use_vga;
                m_go       = 1'b1;
                m_wr       = !use_vga;
                m_cur_wr   = !use_vga;
                m_cur_drop = 1'b0;
                if (use_vga) begin
                    m_addr = (m_disp ? BUF1 : BUF0) + 23'(m_rptr);
                end else if (m_wptr == FW) begin
                    m_addr     = SCRATCH;
                    m_cur_drop = 1'b1;
                    m_drop     = 1'b1;
                end else begin
                    m_addr = (m_disp ? BUF0 : BUF1) + 23'(m_wptr);
                end
                m_busy   = 1'b1;
                done_due = cyc + 5;
            end
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic vr, input logic cfs,
                                 input logic vfs, input logic rstn);
        cam_req         = cr;
        vga_req         = vr;
        cam_frame_start = cfs;
        vga_frame_start = vfs;
        rst_i           = rstn;
        brst_Done       = (cyc == done_due);
        @(posedge clk_i);
        modelStep(cr, vr, cfs, vfs, brst_Done, rstn);
        cyc++;
        #1;
        if (brst_Go && brst_Wr) dut_wr_gos++;
        checkOutput("brst_Go", 32'(brst_Go), 32'(m_go));
        checkOutput("brst_Wr", 32'(brst_Wr), 32'(m_wr));
        checkOutput("brst_Addr", 32'(brst_Addr), 32'(m_addr));
        checkOutput("vga_rst", 32'(vga_rst), 32'(m_vga_rst));
        checkOutput("disp_buf", 32'(disp_buf), 32'(m_disp));
        checkOutput("swap", 32'(swap), 32'(m_swap));
        checkOutput("frame_drop", 32'(frame_drop), 32'(m_drop));
    endtask

    // Hold a request until the DUT issues, then idle until the burst has drained.
    task automatic runBurst(input logic cr, input logic vr, output logic [22:0] addr,
                            output logic drop);
        logic got = 1'b0;
        addr = '0;
        drop = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus(cr, vr, 1'b0, 1'b0, 1'b1);
            if (brst_Go) begin
                got  = 1'b1;
                addr = brst_Addr;
                drop = frame_drop;
            end
        end
        checkOutput("burst_issued", 32'(got), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [22:0] addr;
        logic        drop;
        logic        got;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reads only: prefill releases vga_rst
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("prefill_released", 32'(vga_rst), 32'd0);

        // Both requesting until one full frame has been written
        dut_wr_gos = 0;
        for (int i = 0; i < 200 && dut_wr_gos < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("frame_writes", 32'(dut_wr_gos), 32'd4);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Completed frame swaps at the VGA frame start
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("swap_pulse", 32'(swap), 32'd1);
        checkOutput("disp_after_swap", 32'(disp_buf), 32'd0);
        runBurst(1'b0, 1'b1, addr, drop);
        checkOutput("read_after_swap", 32'(addr), 32'(BUF0));

        // Overrun camera burst lands in scratch
        runBurst(1'b1, 1'b0, addr, drop);
        checkOutput("overrun_addr", 32'(addr), 32'(SCRATCH));
        checkOutput("overrun_drop", 32'(drop), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        runBurst(1'b1, 1'b0, addr, drop);
        checkOutput("write_after_cam_start", 32'(addr), 32'(BUF1));

        // Simultaneous frame starts with a complete frame: no swap
        for (int i = 0; i < 3; i++) runBurst(1'b1, 1'b0, addr, drop);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("no_swap_same_cycle", 32'(swap), 32'd0);
        checkOutput("disp_kept", 32'(disp_buf), 32'd0);

        // Reset while a read burst is waiting for Done
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            got = brst_Go;
        end
        checkOutput("reset_test_issue", 32'(got), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_vga_rst", 32'(vga_rst), 32'd1);
        checkOutput("reset_disp_buf", 32'(disp_buf), 32'd1);
        checkOutput("reset_addr", 32'(brst_Addr), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with sporadic frame events
        for (int i = 0; i < 2500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
